// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite encodings for the master arbiter and its helpers.
// HTRANS, HBURST and HSIZE values as they appear on the bus.
package ahb_master_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam int MASTER_IDX_W = 2;

endpackage

// File: rtl/ahb_master_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping around to the lowest set request below it.
module ahb_master_arbiter_rr_priority_picker
    import ahb_master_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [MASTER_IDX_W-1:0]   last,
    output logic [MASTER_IDX_W-1:0]   next_idx,
    output logic                      valid
);

    logic                    hi_valid;
    logic [MASTER_IDX_W-1:0] hi_idx;
    logic                    lo_valid;
    logic [MASTER_IDX_W-1:0] lo_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_valid = 1'b1;
                lo_idx   = MASTER_IDX_W'(i);
                if (MASTER_IDX_W'(i) > last) begin
                    hi_valid = 1'b1;
                    hi_idx   = MASTER_IDX_W'(i);
                end
            end
        end
    end

    assign valid    = lo_valid;
    assign next_idx = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Multi-master AHB-Lite arbiter and master-side mux. Bus ownership moves only
// when the owner is IDLE, unlocked and HREADY is high, so no transfer is split.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
    input  logic [NUM_MASTERS*2-1:0]      m_htrans,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [NUM_MASTERS*3-1:0]      m_hsize,
    input  logic [NUM_MASTERS*3-1:0]      m_hburst,
    input  logic [NUM_MASTERS*4-1:0]      m_hprot,
    input  logic [NUM_MASTERS-1:0]        m_hmastlock,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]        m_hready,
    input  logic                          HREADY,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic                          HMASTLOCK,
    output logic [DATA_W-1:0]             HWDATA,
    output logic [NUM_MASTERS-1:0]        hgrant,
    output logic [MASTER_IDX_W-1:0]       hmaster,
    output logic [MASTER_IDX_W-1:0]       hmaster_data
);

    localparam int N = NUM_MASTERS;
    localparam logic [MASTER_IDX_W-1:0] DEF_IDX = MASTER_IDX_W'(DEFAULT_MASTER);

    logic [MASTER_IDX_W-1:0] owner;
    logic [MASTER_IDX_W-1:0] owner_next;
    logic [MASTER_IDX_W-1:0] data_owner;
    logic [MASTER_IDX_W-1:0] pick_idx;
    logic                    pick_valid;
    logic [N-1:0]            req;
    logic [N-1:0]            other_req;
    logic                    handover;

    always_comb begin
        req    = '0;
        hgrant = '0;
        for (int i = 0; i < N; i++) begin
            req[i]    = (m_htrans[i*2 +: 2] == HTRANS_NONSEQ);
            hgrant[i] = (owner == MASTER_IDX_W'(i));
        end
    end

    assign other_req = req & ~hgrant;

    ahb_master_arbiter_rr_priority_picker #(
        .N (N)
    ) u_picker (
        .req      (other_req),
        .last     (owner),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Address-phase mux follows the owner; HWDATA follows the data-phase owner.
    always_comb begin
        HADDR     = '0;
        HTRANS    = HTRANS_IDLE;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HBURST    = '0;
        HPROT     = '0;
        HMASTLOCK = 1'b0;
        HWDATA    = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == MASTER_IDX_W'(i)) begin
                HADDR     = m_haddr[i*ADDR_W +: ADDR_W];
                HTRANS    = m_htrans[i*2 +: 2];
                HWRITE    = m_hwrite[i];
                HSIZE     = m_hsize[i*3 +: 3];
                HBURST    = m_hburst[i*3 +: 3];
                HPROT     = m_hprot[i*4 +: 4];
                HMASTLOCK = m_hmastlock[i];
            end
            if (data_owner == MASTER_IDX_W'(i)) begin
                HWDATA = m_hwdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Non-owners see a zero-wait OKAY for IDLE and are stalled otherwise.
    always_comb begin
        m_hready = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == MASTER_IDX_W'(i)) begin
                m_hready[i] = HREADY;
            end else begin
                m_hready[i] = (m_htrans[i*2 +: 2] == HTRANS_IDLE);
            end
        end
    end

    assign handover = (HTRANS == HTRANS_IDLE) && !HMASTLOCK && HREADY && pick_valid;

    always_comb begin
        owner_next = owner;
        if (handover) begin
            owner_next = pick_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= DEF_IDX;
            data_owner <= DEF_IDX;
        end else begin
            owner <= owner_next;
            if (HREADY) begin
                data_owner <= owner;
            end
        end
    end

    assign hmaster      = owner;
    assign hmaster_data = data_owner;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with three masters (0=CPU, 1=DMA, 2=aux).
// Inputs change just after the rising edge; outputs are checked a step later.
module tb_ahb_master_arbiter;

    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hready_s = 1'b1;

    logic [1:0]  tr [N];
    logic [31:0] ad [N];
    logic [31:0] wd [N];
    logic        wr [N];
    logic        lk [N];
    logic [2:0]  bu [N];

    logic [N*AW-1:0] m_haddr;
    logic [N*2-1:0]  m_htrans;
    logic [N-1:0]    m_hwrite;
    logic [N*3-1:0]  m_hsize;
    logic [N*3-1:0]  m_hburst;
    logic [N*4-1:0]  m_hprot;
    logic [N-1:0]    m_hmastlock;
    logic [N*DW-1:0] m_hwdata;
    logic [N-1:0]    m_hready;
    logic [AW-1:0]   HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic            HMASTLOCK;
    logic [DW-1:0]   HWDATA;
    logic [N-1:0]    hgrant;
    logic [1:0]      hmaster;
    logic [1:0]      hmaster_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        m_haddr     = '0;
        m_htrans    = '0;
        m_hwrite    = '0;
        m_hsize     = '0;
        m_hburst    = '0;
        m_hprot     = '0;
        m_hmastlock = '0;
        m_hwdata    = '0;
        for (int i = 0; i < N; i++) begin
            m_haddr[i*AW +: AW] = ad[i];
            m_htrans[i*2 +: 2]  = tr[i];
            m_hwrite[i]         = wr[i];
            m_hsize[i*3 +: 3]   = 3'b010;
            m_hburst[i*3 +: 3]  = bu[i];
            m_hprot[i*4 +: 4]   = 4'b0011;
            m_hmastlock[i]      = lk[i];
            m_hwdata[i*DW +: DW] = wd[i];
        end
    end

    ahb_master_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0),
        .ADDR_W         (AW),
        .DATA_W         (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_haddr      (m_haddr),
        .m_htrans     (m_htrans),
        .m_hwrite     (m_hwrite),
        .m_hsize      (m_hsize),
        .m_hburst     (m_hburst),
        .m_hprot      (m_hprot),
        .m_hmastlock  (m_hmastlock),
        .m_hwdata     (m_hwdata),
        .m_hready     (m_hready),
        .HREADY       (hready_s),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HPROT        (HPROT),
        .HMASTLOCK    (HMASTLOCK),
        .HWDATA       (HWDATA),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tr[i] = IDLE; ad[i] = '0; wd[i] = '0; wr[i] = 1'b0; lk[i] = 1'b0; bu[i] = 3'b000;
        end
        #1 reset = 1'b1;
        #2;
        check("rst_hgrant", 64'(hgrant), 64'h1);
        check("rst_hmaster", 64'(hmaster), 64'h0);
        check("rst_hmaster_data", 64'(hmaster_data), 64'h0);
        check("rst_m_hready", 64'(m_hready), 64'h7);
        check("rst_htrans", 64'(HTRANS), 64'(IDLE));
        step; step;
        reset = 1'b0;
        step;
        check("idle_no_switch", 64'(hgrant), 64'h1);

        // DMA requests while the CPU idles
        tr[1] = NSEQ; ad[1] = 32'h100; wr[1] = 1'b1;
        #1;
        check("dma_stalled", 64'(m_hready), 64'h5);
        check("dma_req_hmaster", 64'(hmaster), 64'h0);
        step;
        check("dma_grant_hmaster", 64'(hmaster), 64'h1);
        check("dma_grant_hgrant", 64'(hgrant), 64'h2);
        check("dma_haddr", 64'(HADDR), 64'h100);
        check("dma_htrans", 64'(HTRANS), 64'(NSEQ));
        check("dma_hmaster_data", 64'(hmaster_data), 64'h0);
        hready_s = 1'b0;
        #1;
        check("dma_hready_follow", 64'(m_hready), 64'h5);
        hready_s = 1'b1;

        // DMA INCR4 burst with the CPU requesting throughout
        step;
        ad[1] = 32'h200; bu[1] = 3'b011; wd[1] = 32'hD100;
        tr[0] = NSEQ; ad[0] = 32'h300; wr[0] = 1'b0;
        #1;
        check("burst_hmaster_data", 64'(hmaster_data), 64'h1);
        check("burst_hwdata0", 64'(HWDATA), 64'hD100);
        check("burst_cpu_stall", 64'(m_hready), 64'h6);
        check("burst_hburst", 64'(HBURST), 64'h3);
        check("burst_hwrite", 64'(HWRITE), 64'h1);
        step;
        tr[1] = SEQ; ad[1] = 32'h204; wd[1] = 32'hD200;
        #1;
        check("burst_frozen1", 64'(hmaster), 64'h1);
        check("burst_hwdata1", 64'(HWDATA), 64'hD200);
        step;
        ad[1] = 32'h208; wd[1] = 32'hD204;
        step;
        ad[1] = 32'h20C; wd[1] = 32'hD208;
        #1;
        check("burst_haddr_last", 64'(HADDR), 64'h20C);
        check("burst_frozen3", 64'(hmaster), 64'h1);

        // two wait states on the final beat, DMA already IDLE
        step;
        tr[1] = IDLE; wd[1] = 32'hD20C; hready_s = 1'b0;
        step;
        check("ws_frozen", 64'(hmaster), 64'h1);
        check("ws_data_hold", 64'(hmaster_data), 64'h1);
        check("ws_hwdata", 64'(HWDATA), 64'hD20C);
        check("ws_m_hready", 64'(m_hready), 64'h4);
        step;
        hready_s = 1'b1;
        #1;
        check("ws_frozen2", 64'(hmaster), 64'h1);
        step;
        check("cpu_grant_hmaster", 64'(hmaster), 64'h0);
        check("cpu_grant_hgrant", 64'(hgrant), 64'h1);
        check("cpu_haddr", 64'(HADDR), 64'h300);
        check("cpu_grant_data_owner", 64'(hmaster_data), 64'h1);
        check("cpu_m_hready", 64'(m_hready), 64'h7);
        step;
        tr[0] = IDLE; wd[0] = 32'hDC0;
        #1;
        check("cpu_data_owner", 64'(hmaster_data), 64'h0);
        check("cpu_hwdata", 64'(HWDATA), 64'hDC0);

        // locked CPU sequence: read, locked IDLE, write, unlock
        step;
        tr[0] = NSEQ; ad[0] = 32'h400; lk[0] = 1'b1;
        tr[1] = NSEQ; ad[1] = 32'h500; wr[1] = 1'b0;
        #1;
        check("lock_hmastlock", 64'(HMASTLOCK), 64'h1);
        step;
        tr[0] = IDLE;
        step;
        check("lock_hold_idle", 64'(hmaster), 64'h0);
        tr[0] = NSEQ; ad[0] = 32'h404; wr[0] = 1'b1;
        step;
        tr[0] = IDLE; lk[0] = 1'b0;
        #1;
        check("lock_hold_write", 64'(hmaster), 64'h0);
        step;
        check("unlock_handover", 64'(hmaster), 64'h1);
        check("unlock_haddr", 64'(HADDR), 64'h500);
        check("unlock_hmastlock", 64'(HMASTLOCK), 64'h0);

        // round-robin among three masters
        step;
        tr[1] = IDLE;
        tr[0] = NSEQ; ad[0] = 32'h600;
        tr[2] = NSEQ; ad[2] = 32'h700;
        #1;
        check("rr_stall_both", 64'(m_hready), 64'h2);
        step;
        check("rr_pick2_hmaster", 64'(hmaster), 64'h2);
        check("rr_pick2_hgrant", 64'(hgrant), 64'h4);
        check("rr_pick2_haddr", 64'(HADDR), 64'h700);
        check("rr_pick2_m_hready", 64'(m_hready), 64'h6);
        step;
        tr[2] = IDLE;
        tr[1] = NSEQ; ad[1] = 32'h510;
        step;
        check("rr_wrap_pick0", 64'(hmaster), 64'h0);
        check("rr_wrap_haddr", 64'(HADDR), 64'h600);
        step;
        tr[0] = IDLE;
        tr[2] = NSEQ; ad[2] = 32'h710;
        step;
        check("rr_pick1", 64'(hmaster), 64'h1);
        check("rr_pick1_haddr", 64'(HADDR), 64'h510);
        step;
        tr[1] = IDLE;
        tr[0] = NSEQ; ad[0] = 32'h610;
        step;
        check("rr_next_pick2", 64'(hmaster), 64'h2);
        check("rr_next_hgrant", 64'(hgrant), 64'h4);
        step;
        tr[2] = SEQ; ad[2] = 32'h714;
        #1;
        check("pre_rst_data_owner", 64'(hmaster_data), 64'h2);

        // reset in the middle of master 2's burst
        reset = 1'b1;
        #1;
        check("midrst_hgrant", 64'(hgrant), 64'h1);
        check("midrst_hmaster", 64'(hmaster), 64'h0);
        check("midrst_hmaster_data", 64'(hmaster_data), 64'h0);
        check("midrst_haddr", 64'(HADDR), 64'h610);
        step;
        reset = 1'b0;
        for (int i = 0; i < N; i++) tr[i] = IDLE;

        // SEQ is not a request, and an idle bus parks on the current owner
        tr[1] = NSEQ; ad[1] = 32'h800;
        step;
        check("park_grant_dma", 64'(hmaster), 64'h1);
        tr[1] = IDLE;
        tr[0] = SEQ; ad[0] = 32'h900;
        step; step;
        check("seq_no_request", 64'(hmaster), 64'h1);
        check("seq_stalled", 64'(m_hready), 64'h6);
        tr[0] = IDLE;
        step; step;
        check("park_on_owner", 64'(hmaster), 64'h1);
        check("park_hgrant", 64'(hgrant), 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
